// File: rtl/five_stage_fetch_unit.sv
// five_stage_fetch_unit: PC owner issuing one-at-a-time instruction fetches into a 2-entry decode FIFO.
// A redirect flushes the FIFO and drops any response still in flight.
module five_stage_fetch_unit #(
    parameter int                      CORE            = 0,
    parameter int                      ADDRESS_BITS    = 20,
    parameter int                      DATA_WIDTH      = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0,
    parameter int                      SCAN_CYCLES_MIN = 0,
    parameter int                      SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              next_PC_sel,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    i_mem_read,
    input  logic                    stall_decode,
    output logic                    fetch_request,
    output logic [ADDRESS_BITS-1:0] fetch_address_out,
    input  logic                    fetch_ready,
    input  logic                    fetch_valid,
    input  logic [ADDRESS_BITS-1:0] fetch_address_in,
    input  logic [DATA_WIDTH-1:0]   fetch_data_in,
    output logic [ADDRESS_BITS-1:0] issue_PC,
    output logic [DATA_WIDTH-1:0]   instruction_decode,
    output logic [ADDRESS_BITS-1:0] inst_PC_decode,
    output logic                    inst_valid_decode,
    input  logic                    scan
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d, issue_q, issue_d, exp_q, exp_d;
    logic [ADDRESS_BITS-1:0] h_pc_q, h_pc_d, t_pc_q, t_pc_d;
    logic [DATA_WIDTH-1:0]   h_data_q, h_data_d, t_data_q, t_data_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    drop_q, drop_d;
    logic                    redirect, accept, take, push, pop;

    // Scan tracing is a simulation-only feature; these inputs have no hardware effect.
    logic unused_scan;
    assign unused_scan = ^{scan, CORE[0], SCAN_CYCLES_MIN[0], SCAN_CYCLES_MAX[0]};

    always_comb begin
        redirect      = (next_PC_sel != 2'b00) && (state_q != S_IDLE);
        fetch_request = (state_q == S_REQ) && i_mem_read && (cnt_q != 2'd2) && !redirect;
        accept        = fetch_request && fetch_ready;
        take          = (state_q == S_WAIT) && fetch_valid;
        push          = take && !redirect && !drop_q && (fetch_address_in == exp_q);
        pop           = (cnt_q != 2'd0) && !stall_decode;
        state_d       = state_q;
        pc_d          = pc_q;
        issue_d       = issue_q;
        exp_d         = exp_q;
        drop_d        = drop_q;
        cnt_d         = cnt_q;
        h_pc_d        = h_pc_q;
        h_data_d      = h_data_q;
        t_pc_d        = t_pc_q;
        t_data_d      = t_data_q;
        case (state_q)
            S_IDLE: state_d = start ? S_REQ : S_IDLE;
            S_REQ: begin
                if (accept) begin
                    state_d = S_WAIT;
                    issue_d = pc_q;
                    exp_d   = pc_q;
                    pc_d    = pc_q + ADDRESS_BITS'(4);
                end
            end
            S_WAIT: begin
                if (take) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (push && pop) begin
            if (cnt_q == 2'd1) begin
                h_pc_d   = fetch_address_in;
                h_data_d = fetch_data_in;
            end else begin
                h_pc_d   = t_pc_q;
                h_data_d = t_data_q;
                t_pc_d   = fetch_address_in;
                t_data_d = fetch_data_in;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                h_pc_d   = fetch_address_in;
                h_data_d = fetch_data_in;
            end else begin
                t_pc_d   = fetch_address_in;
                t_data_d = fetch_data_in;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            h_pc_d   = t_pc_q;
            h_data_d = t_data_q;
            cnt_d    = cnt_q - 2'd1;
        end
        // Redirect overrides the sequential PC, push and pop decided above.
        if (redirect) begin
            pc_d   = target_PC;
            cnt_d  = 2'd0;
            drop_d = ((state_q == S_WAIT) && !fetch_valid) || accept;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            issue_q  <= RESET_PC;
            exp_q    <= RESET_PC;
            drop_q   <= 1'b0;
            cnt_q    <= 2'd0;
            h_pc_q   <= '0;
            h_data_q <= NOP;
            t_pc_q   <= '0;
            t_data_q <= NOP;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            issue_q  <= issue_d;
            exp_q    <= exp_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            h_pc_q   <= h_pc_d;
            h_data_q <= h_data_d;
            t_pc_q   <= t_pc_d;
            t_data_q <= t_data_d;
        end
    end

    assign fetch_address_out  = pc_q;
    assign issue_PC           = issue_q;
    assign inst_valid_decode  = cnt_q != 2'd0;
    assign instruction_decode = inst_valid_decode ? h_data_q : NOP;
    assign inst_PC_decode     = inst_valid_decode ? h_pc_q : '0;

endmodule

// File: tb/tb_five_stage_fetch_unit.sv
// tb_five_stage_fetch_unit: directed scenarios against a 1-cycle-latency memory model,
// with a scoreboard of expected decode words filled on each accepted request.
module tb_five_stage_fetch_unit;
    localparam int AB = 20;
    localparam int DW = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [AB-1:0] pc;
        logic [DW-1:0] d;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    next_PC_sel = 2'b00;
    logic [AB-1:0] target_PC = '0;
    logic          i_mem_read = 1'b1;
    logic          stall_decode = 1'b0;
    logic          fetch_request;
    logic [AB-1:0] fetch_address_out;
    logic          fetch_ready = 1'b1;
    logic          fetch_valid = 1'b0;
    logic [AB-1:0] fetch_address_in = '0;
    logic [DW-1:0] fetch_data_in = '0;
    logic [AB-1:0] issue_PC;
    logic [DW-1:0] instruction_decode;
    logic [AB-1:0] inst_PC_decode;
    logic          inst_valid_decode;
    logic          scan = 1'b0;

    int   vec = 0;
    int   bad = 0;
    int   pops = 0;
    int   pops_base;
    ent_t sb[$];

    five_stage_fetch_unit dut (
        .clock(clock), .reset(reset), .start(start), .next_PC_sel(next_PC_sel),
        .target_PC(target_PC), .i_mem_read(i_mem_read), .stall_decode(stall_decode),
        .fetch_request(fetch_request), .fetch_address_out(fetch_address_out),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_address_in(fetch_address_in), .fetch_data_in(fetch_data_in),
        .issue_PC(issue_PC), .instruction_decode(instruction_decode),
        .inst_PC_decode(inst_PC_decode), .inst_valid_decode(inst_valid_decode), .scan(scan)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mem(input logic [AB-1:0] a);
        return {12'hC0D, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check any decode pop, record any accept, then answer it one cycle later.
    task automatic cyc();
        logic          acc_v;
        logic [AB-1:0] acc_a;
        ent_t          e;
        #1;
        acc_v = fetch_request && fetch_ready;
        acc_a = fetch_address_out;
        if (next_PC_sel != 2'b00) sb.delete();
        else if (inst_valid_decode && !stall_decode) begin
            if (sb.size() != 0) e = sb.pop_front();
            else e = '1;
            chk("dec_pc", inst_PC_decode, e.pc);
            chk("dec_data", instruction_decode, e.d);
            pops++;
        end
        if (acc_v && next_PC_sel == 2'b00) sb.push_back({acc_a, mem(acc_a)});
        @(posedge clock);
        @(negedge clock);
        fetch_valid      = acc_v;
        fetch_address_in = acc_a;
        fetch_data_in    = mem(acc_a);
    endtask

    task automatic expect_req(input string tag, input logic [AB-1:0] a);
        int n = 0;
        #1;
        while (!(fetch_request && fetch_ready) && n < 8) begin
            cyc();
            #1;
            n++;
        end
        chk({tag, "_req"}, fetch_request, 1);
        chk({tag, "_addr"}, fetch_address_out, a);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_req", fetch_request, 0);
        chk("rst_issue", issue_PC, 0);
        chk("rst_valid", inst_valid_decode, 0);
        chk("rst_inst", instruction_decode, NOP);
        chk("rst_ipc", inst_PC_decode, 0);
        reset = 1'b1;
        cyc();
        chk("idle_req", fetch_request, 0);

        // Sequential fetch 0,4,8
        pulse_start();
        pops_base = pops;
        expect_req("t1_0", 20'h0);
        cyc();
        chk("t1_issue0", issue_PC, 20'h0);
        chk("t1_wait_req", fetch_request, 0);
        expect_req("t1_4", 20'h4);
        cyc();
        chk("t1_issue4", issue_PC, 20'h4);
        expect_req("t1_8", 20'h8);
        cyc();
        chk("t1_issue8", issue_PC, 20'h8);
        i_mem_read = 1'b0;
        repeat (3) cyc();
        chk("t1_pops", pops - pops_base, 3);
        chk("t1_sb_empty", sb.size(), 0);

        // Stall decode: FIFO fills to 2, requests stop, then drain in order
        reset = 1'b0;
        sb.delete();
        fetch_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        i_mem_read = 1'b1;
        stall_decode = 1'b1;
        pulse_start();
        pops_base = pops;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i >= 3) chk("t2_full_req", fetch_request, 0);
        end
        chk("t2_valid", inst_valid_decode, 1);
        chk("t2_head", inst_PC_decode, 20'h0);
        chk("t2_issue", issue_PC, 20'h4);
        chk("t2_nopop", pops - pops_base, 0);
        stall_decode = 1'b0;
        cyc();
        expect_req("t2_8", 20'h8);
        cyc();
        i_mem_read = 1'b0;
        repeat (3) cyc();
        chk("t2_pops", pops - pops_base, 3);

        // Redirect while waiting on 0x10
        i_mem_read = 1'b1;
        expect_req("t3_c", 20'hC);
        cyc();
        expect_req("t3_10", 20'h10);
        cyc();
        next_PC_sel = 2'b01;
        target_PC   = 20'h40;
        cyc();
        next_PC_sel = 2'b00;
        chk("t3_flushed", inst_valid_decode, 0);
        expect_req("t3_40", 20'h40);
        cyc();
        cyc();
        chk("t3_dec_valid", inst_valid_decode, 1);
        chk("t3_dec_pc", inst_PC_decode, 20'h40);

        // Redirect in the cycle a request would be accepted
        next_PC_sel = 2'b10;
        target_PC   = 20'h20;
        #1;
        chk("t4_gate1", fetch_request, 0);
        cyc();
        next_PC_sel = 2'b11;
        target_PC   = 20'h80;
        #1;
        chk("t4_addr20", fetch_address_out, 20'h20);
        chk("t4_gate2", fetch_request, 0);
        cyc();
        next_PC_sel = 2'b00;
        expect_req("t4_80", 20'h80);
        cyc();
        chk("t4_issue", issue_PC, 20'h80);
        cyc();
        chk("t4_head", inst_PC_decode, 20'h80);

        // Memory not ready: request held; i_mem_read low drops it
        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold_req", fetch_request, 1);
            chk("t5_hold_addr", fetch_address_out, 20'h84);
            cyc();
        end
        i_mem_read = 1'b0;
        #1;
        chk("t5_rd_off", fetch_request, 0);
        i_mem_read  = 1'b1;
        fetch_ready = 1'b1;
        expect_req("t5_84", 20'h84);
        cyc();
        cyc();

        // PC wrap, then reset while waiting and a late response
        next_PC_sel = 2'b01;
        target_PC   = 20'hFFFFC;
        cyc();
        next_PC_sel = 2'b00;
        expect_req("t6_top", 20'hFFFFC);
        cyc();
        chk("t6_issue_top", issue_PC, 20'hFFFFC);
        cyc();
        expect_req("t6_wrap", 20'h0);
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_rst_req", fetch_request, 0);
        chk("t6_rst_valid", inst_valid_decode, 0);
        chk("t6_rst_issue", issue_PC, 0);
        chk("t6_rst_inst", instruction_decode, NOP);
        sb.delete();
        fetch_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        fetch_valid      = 1'b1;
        fetch_address_in = 20'h0;
        fetch_data_in    = mem(20'h0);
        cyc();
        chk("t6_late_valid", inst_valid_decode, 0);
        chk("t6_idle_req", fetch_request, 0);
        pulse_start();
        pops_base = pops;
        expect_req("t6_restart", 20'h0);
        repeat (3) cyc();
        chk("t6_pops", pops - pops_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
